// File: rtl/rs_alu_station_pkg.sv
// Shared constants for the ALU reservation station: sizes, boolean levels, ALU opcodes.
package rs_alu_station_pkg;
  localparam int RSSZ  = 16;
  localparam int ROBBW = 4;
  localparam int CDBN  = 2;
  localparam int XLEN  = 32;
  localparam int OPW   = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 6'd0,
    OP_SUB  = 6'd1,
    OP_AND  = 6'd2,
    OP_OR   = 6'd3,
    OP_XOR  = 6'd4,
    OP_SLL  = 6'd5,
    OP_SRL  = 6'd6,
    OP_SRA  = 6'd7,
    OP_SLT  = 6'd8,
    OP_SLTU = 6'd9
  } alu_op_e;
endpackage

// File: rtl/rs_alu_station_pick.sv
// Lowest-index priority encoder: flags whether any request is set and returns its index.
module rs_pick #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end
endmodule

// File: rtl/rs_alu_station.sv
// ALU reservation station: holds issued ops until both operands arrive via CDB, then
// dispatches the lowest-index ready entry into registered ex_* outputs.
module rs_alu_station
  import rs_alu_station_pkg::*;
#(
  parameter int RS_SIZE   = RSSZ,
  parameter int ROB_BW    = ROBBW,
  parameter int CDB_PORTS = CDBN
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clr_in,
  input  logic                        issue_valid,
  input  logic [OPW-1:0]              issue_op,
  input  logic [XLEN-1:0]             issue_pc,
  input  logic [XLEN-1:0]             issue_imm,
  input  logic                        issue_q1_busy,
  input  logic                        issue_q2_busy,
  input  logic [ROB_BW-1:0]           issue_q1,
  input  logic [ROB_BW-1:0]           issue_q2,
  input  logic [XLEN-1:0]             issue_v1,
  input  logic [XLEN-1:0]             issue_v2,
  input  logic [ROB_BW-1:0]           issue_rob_id,
  output logic                        rs_full,
  input  logic [CDB_PORTS-1:0]        cdb_valid,
  input  logic [CDB_PORTS*ROB_BW-1:0] cdb_rob_id,
  input  logic [CDB_PORTS*XLEN-1:0]   cdb_value,
  output logic                        ex_valid,
  output logic [OPW-1:0]              ex_op,
  output logic [XLEN-1:0]             ex_pc,
  output logic [XLEN-1:0]             ex_imm,
  output logic [XLEN-1:0]             ex_v1,
  output logic [XLEN-1:0]             ex_v2,
  output logic [ROB_BW-1:0]           ex_rob_id
);
  localparam int IW = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy, p1, p2, ready_vec;
  logic [OPW-1:0]     op_q  [RS_SIZE];
  logic [XLEN-1:0]    pc_q  [RS_SIZE];
  logic [XLEN-1:0]    imm_q [RS_SIZE];
  logic [XLEN-1:0]    v1_q  [RS_SIZE];
  logic [XLEN-1:0]    v2_q  [RS_SIZE];
  logic [ROB_BW-1:0]  rob_q [RS_SIZE];
  logic [ROB_BW-1:0]  q1_q  [RS_SIZE];
  logic [ROB_BW-1:0]  q2_q  [RS_SIZE];

  logic [RS_SIZE-1:0] w1_hit, w2_hit;
  logic [XLEN-1:0]    w1_val [RS_SIZE];
  logic [XLEN-1:0]    w2_val [RS_SIZE];
  logic               b1_hit, b2_hit;
  logic [XLEN-1:0]    b1_val, b2_val;
  logic               free_found, rdy_found;
  logic [IW-1:0]      free_idx, rdy_idx;

  // {hit, value}; walking ports downward lets the lowest matching port win.
  function automatic logic [XLEN:0] cdb_match(input logic [ROB_BW-1:0] tag);
    logic [XLEN:0] r;
    r = '0;
    for (int p = CDB_PORTS - 1; p >= 0; p--)
      if (cdb_valid[p] && cdb_rob_id[p*ROB_BW +: ROB_BW] == tag)
        r = {1'b1, cdb_value[p*XLEN +: XLEN]};
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      {w1_hit[i], w1_val[i]} = cdb_match(q1_q[i]);
      {w2_hit[i], w2_val[i]} = cdb_match(q2_q[i]);
    end
    {b1_hit, b1_val} = cdb_match(issue_q1);
    {b2_hit, b2_val} = cdb_match(issue_q2);
  end

  assign rs_full   = &busy;
  assign ready_vec = busy & ~p1 & ~p2;

  rs_pick #(.N(RS_SIZE), .IW(IW)) u_free_pick (.req(~busy),     .found(free_found), .idx(free_idx));
  rs_pick #(.N(RS_SIZE), .IW(IW)) u_rdy_pick  (.req(ready_vec), .found(rdy_found),  .idx(rdy_idx));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy      <= '0;
      p1        <= '0;
      p2        <= '0;
      ex_valid  <= FALSE;
      ex_op     <= '0;
      ex_pc     <= '0;
      ex_imm    <= '0;
      ex_v1     <= '0;
      ex_v2     <= '0;
      ex_rob_id <= '0;
    end else if (rdy_in) begin
      if (clr_in) begin
        busy     <= '0;
        ex_valid <= FALSE;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i] && p1[i] && w1_hit[i]) begin
            p1[i]   <= FALSE;
            v1_q[i] <= w1_val[i];
          end
          if (busy[i] && p2[i] && w2_hit[i]) begin
            p2[i]   <= FALSE;
            v2_q[i] <= w2_val[i];
          end
        end
        ex_valid <= rdy_found;
        if (rdy_found) begin
          busy[rdy_idx] <= FALSE;
          ex_op         <= op_q[rdy_idx];
          ex_pc         <= pc_q[rdy_idx];
          ex_imm        <= imm_q[rdy_idx];
          ex_v1         <= v1_q[rdy_idx];
          ex_v2         <= v2_q[rdy_idx];
          ex_rob_id     <= rob_q[rdy_idx];
        end
        // The free slot is never the dispatching one, so both writes can share the edge.
        if (issue_valid && free_found) begin
          busy[free_idx]  <= TRUE;
          op_q[free_idx]  <= issue_op;
          pc_q[free_idx]  <= issue_pc;
          imm_q[free_idx] <= issue_imm;
          rob_q[free_idx] <= issue_rob_id;
          q1_q[free_idx]  <= issue_q1;
          q2_q[free_idx]  <= issue_q2;
          p1[free_idx]    <= issue_q1_busy && !b1_hit;
          p2[free_idx]    <= issue_q2_busy && !b2_hit;
          v1_q[free_idx]  <= (issue_q1_busy && b1_hit) ? b1_val : issue_v1;
          v2_q[free_idx]  <= (issue_q2_busy && b2_hit) ? b2_val : issue_v2;
        end
      end
    end
  end
endmodule

// File: tb/tb_rs_alu_station.sv
// Scoreboard bench for rs_alu_station: an entry-level model predicts dispatches into a queue,
// a monitor compares every DUT cycle against it.
module tb_rs_alu_station;
  localparam int RS = 16;
  localparam int RB = 4;
  localparam int CP = 2;

  logic            clk = 1'b0;
  logic            rst_in, rdy_in, clr_in;
  logic            issue_valid, issue_q1_busy, issue_q2_busy;
  logic [5:0]      issue_op;
  logic [31:0]     issue_pc, issue_imm, issue_v1, issue_v2;
  logic [RB-1:0]   issue_q1, issue_q2, issue_rob_id;
  logic            rs_full;
  logic [CP-1:0]   cdb_valid;
  logic [CP*RB-1:0] cdb_rob_id;
  logic [CP*32-1:0] cdb_value;
  logic            ex_valid;
  logic [5:0]      ex_op;
  logic [31:0]     ex_pc, ex_imm, ex_v1, ex_v2;
  logic [RB-1:0]   ex_rob_id;

  rs_alu_station #(.RS_SIZE(RS), .ROB_BW(RB), .CDB_PORTS(CP)) dut (
    .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .issue_valid(issue_valid), .issue_op(issue_op), .issue_pc(issue_pc), .issue_imm(issue_imm),
    .issue_q1_busy(issue_q1_busy), .issue_q2_busy(issue_q2_busy),
    .issue_q1(issue_q1), .issue_q2(issue_q2), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_rob_id(issue_rob_id), .rs_full(rs_full),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
    .ex_valid(ex_valid), .ex_op(ex_op), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_v1(ex_v1), .ex_v2(ex_v2), .ex_rob_id(ex_rob_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit busy; bit [5:0] op; bit [31:0] pc, imm, v1, v2;
    bit [RB-1:0] rob, q1, q2; bit p1, p2;
  } ent_t;
  typedef bit [137:0] exr_t;

  ent_t m[RS];
  exr_t exp_q[$];
  bit   mexv, mact, mfull, mon_en;
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Lowest port carrying the tag supplies the value.
  function automatic bit cdb_find(input bit [RB-1:0] tag, output bit [31:0] val);
    val = '0;
    for (int p = 0; p < CP; p++)
      if (cdb_valid[p] && cdb_rob_id[p*RB +: RB] == tag) begin
        val = cdb_value[p*32 +: 32];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  always @(posedge clk) begin : model
    int d, f;
    bit [31:0] v;
    if (rst_in) begin
      for (int i = 0; i < RS; i++) begin m[i].busy = 0; m[i].p1 = 0; m[i].p2 = 0; end
      mexv = 0; mact = 1;
    end else if (!rdy_in) begin
      mact = 0;
    end else begin
      mact = 1;
      if (clr_in) begin
        for (int i = 0; i < RS; i++) m[i].busy = 0;
        mexv = 0;
      end else begin
        d = -1; f = -1;
        for (int i = 0; i < RS; i++) begin
          if (d < 0 && m[i].busy && !m[i].p1 && !m[i].p2) d = i;
          if (f < 0 && !m[i].busy) f = i;
        end
        mexv = (d >= 0);
        if (d >= 0) begin
          exp_q.push_back({m[d].op, m[d].pc, m[d].imm, m[d].v1, m[d].v2, m[d].rob});
          m[d].busy = 0;
        end
        for (int i = 0; i < RS; i++) if (m[i].busy) begin
          if (m[i].p1 && cdb_find(m[i].q1, v)) begin m[i].p1 = 0; m[i].v1 = v; end
          if (m[i].p2 && cdb_find(m[i].q2, v)) begin m[i].p2 = 0; m[i].v2 = v; end
        end
        if (issue_valid && f >= 0) begin
          m[f].busy = 1; m[f].op = issue_op; m[f].pc = issue_pc; m[f].imm = issue_imm;
          m[f].rob = issue_rob_id; m[f].q1 = issue_q1; m[f].q2 = issue_q2;
          m[f].p1 = issue_q1_busy; m[f].v1 = issue_v1;
          m[f].p2 = issue_q2_busy; m[f].v2 = issue_v2;
          if (issue_q1_busy && cdb_find(issue_q1, v)) begin m[f].p1 = 0; m[f].v1 = v; end
          if (issue_q2_busy && cdb_find(issue_q2, v)) begin m[f].p2 = 0; m[f].v2 = v; end
        end
      end
    end
    mfull = 1;
    for (int i = 0; i < RS; i++) if (!m[i].busy) mfull = 0;
  end

  exr_t prev;
  always @(posedge clk) begin : monitor
    exr_t cur;
    #1;
    if (mon_en) begin
      cur = {ex_op, ex_pc, ex_imm, ex_v1, ex_v2, ex_rob_id};
      chk("ex_valid", 138'(ex_valid), 138'(mexv));
      chk("rs_full", 138'(rs_full), 138'(mfull));
      if (!mact) chk("ex_hold", cur, prev);
      else if (mexv) begin
        if (exp_q.size() == 0) chk("dispatch_unexpected", cur, '1);
        else chk("dispatch", cur, exp_q.pop_front());
      end
      prev = cur;
    end
  end

  task automatic idle();
    rst_in = 0; rdy_in = 1; clr_in = 0; issue_valid = 0; cdb_valid = '0;
    issue_q1_busy = 0; issue_q2_busy = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); idle(); end
  endtask

  task automatic iss(input bit [5:0] op, input bit q1b, input bit [RB-1:0] q1, input bit [31:0] v1,
                     input bit q2b, input bit [RB-1:0] q2, input bit [31:0] v2,
                     input bit [RB-1:0] rob, input bit [31:0] pc);
    issue_valid = 1; issue_op = op; issue_pc = pc; issue_imm = pc ^ 32'hA5A5_0000;
    issue_q1_busy = q1b; issue_q1 = q1; issue_v1 = v1;
    issue_q2_busy = q2b; issue_q2 = q2; issue_v2 = v2; issue_rob_id = rob;
  endtask

  task automatic cdb(input int p, input bit [RB-1:0] tag, input bit [31:0] val);
    cdb_valid[p] = 1; cdb_rob_id[p*RB +: RB] = tag; cdb_value[p*32 +: 32] = val;
  endtask

  initial begin
    idle();
    issue_op = 0; issue_pc = 0; issue_imm = 0; issue_v1 = 0; issue_v2 = 0;
    issue_q1 = 0; issue_q2 = 0; issue_rob_id = 0; cdb_rob_id = '0; cdb_value = '0;
    rst_in = 1; clr_in = 1;
    @(negedge clk); rst_in = 1;
    @(negedge clk); idle();
    chk("reset_ex", {ex_op, ex_pc, ex_imm, ex_v1, ex_v2, ex_rob_id}, '0);
    chk("reset_ex_valid", 138'(ex_valid), 138'(0));
    chk("reset_rs_full", 138'(rs_full), 138'(0));
    prev = '0;
    mon_en = 1;

    // ADD with both operands ready dispatches on the following edge.
    iss(6'd0, 0, 0, 5, 0, 0, 7, 3, 32'h100); tick();
    @(posedge clk); #2;
    chk("add_ready_v", {ex_valid, ex_v1, ex_v2, ex_rob_id}, {1'b1, 32'd5, 32'd7, 4'd3});
    tick(2);

    // Pending on tag 2, woken by port 1 two cycles later.
    iss(6'd1, 1, 2, 0, 0, 0, 32'h22, 5, 32'h200); tick(3);
    cdb(1, 2, 32'h10); tick(3);

    // Fill every entry (entry i waits on tag i), overflow is dropped.
    for (int i = 0; i < RS; i++) begin iss(6'd2, 1, RB'(i), 0, 0, 0, i, RB'(i), 32'h1000 + i); tick(); end
    chk("full_after_fill", 138'(rs_full), 138'(1));
    iss(6'd3, 0, 0, 1, 0, 0, 2, 15, 32'hDEAD); tick();
    cdb(0, 4, 32'h44); tick(2);
    chk("full_after_free", 138'(rs_full), 138'(0));
    // Reuses entry 4, waiting on tag 12 so it races entry 12 and must win by index.
    iss(6'd4, 1, 12, 0, 0, 0, 3, 9, 32'h2004); tick();
    cdb(0, 12, 32'hC0C0); tick(4);
    clr_in = 1; tick(2);

    // Same-cycle bypass on port 0.
    iss(6'd5, 1, 6, 0, 0, 0, 1, 7, 32'h300); cdb(0, 6, 9); tick(3);

    // Both ports carry tag 11; port 0's value must be captured.
    iss(6'd6, 1, 11, 0, 1, 11, 0, 8, 32'h400); tick(2);
    cdb(0, 11, 32'hAAAA); cdb(1, 11, 32'hBBBB); tick(3);

    // Three ready entries then a flush: nothing dispatches.
    for (int i = 0; i < 3; i++) begin iss(6'd7, 1, 9, 0, 0, 0, i, RB'(i), 32'h500 + i); tick(); end
    cdb(0, 9, 32'h99); tick();
    clr_in = 1; tick();
    @(posedge clk); #2;
    chk("clr_ex_valid", 138'(ex_valid), 138'(0));
    tick(4);

    // Stall with ready entries; flush and issue while stalled are ignored.
    for (int i = 0; i < 3; i++) begin iss(6'd8, 1, 10, 0, 0, 0, i, RB'(i), 32'h600 + i); tick(); end
    cdb(1, 10, 32'h1010); tick(2);
    for (int i = 0; i < 3; i++) begin
      rdy_in = 0; clr_in = 1; iss(6'd9, 0, 0, 1, 0, 0, 1, 1, 32'h700); tick();
    end
    tick(5);

    // Reset in the middle of activity.
    for (int i = 0; i < 2; i++) begin iss(6'd2, 1, 3, 0, 0, 0, i, RB'(i), 32'h800 + i); tick(); end
    rst_in = 1; clr_in = 1; tick();
    cdb(0, 3, 32'h33); tick(3);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 1)
        iss(6'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), RB'($urandom), $urandom,
            1'($urandom_range(0, 1)), RB'($urandom), $urandom, RB'($urandom), $urandom);
      for (int p = 0; p < CP; p++)
        if ($urandom_range(0, 9) < 4) cdb(p, RB'($urandom), $urandom);
      if ($urandom_range(0, 99) < 2) clr_in = 1;
      if ($urandom_range(0, 99) < 10) rdy_in = 0;
      if ($urandom_range(0, 999) < 3) rst_in = 1;
      tick();
    end

    // Drain: wake every tag, then let everything dispatch.
    for (int t = 0; t < (1 << RB); t++) begin cdb(0, RB'(t), 32'(t) * 3); tick(); end
    tick(RS + 4);
    chk("queue_drained", 138'(exp_q.size()), 138'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rs_alu_station.md
RS_ALU_STATION -- requirements
Module: rs_alu_station

Interface
REQ-001 Parameter RS_SIZE, default 16, number of entries; power of two, 2..32.
REQ-002 Parameter ROB_BW, default 4, ROB index width.
REQ-003 Parameter CDB_PORTS, default 2, number of common-data-bus broadcast ports.
REQ-004 clk_in  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 rdy_in  input  1  global ready; low freezes all state.
REQ-007 clr_in  input  1  flush on branch mispredict.
REQ-008 issue_valid  input  1  new instruction offered this cycle.
REQ-009 issue_op  input  6  instruction code; issue_pc, issue_imm  input  32 each.
REQ-010 issue_q1_busy, issue_q2_busy  input  1  operand still pending in ROB.
REQ-011 issue_q1, issue_q2  input  ROB_BW  producer tags; issue_v1, issue_v2  input  32  ready values.
REQ-012 issue_rob_id  input  ROB_BW  destination ROB slot.
REQ-013 rs_full  output  1  no free entry (combinational from entry busy bits).
REQ-014 cdb_valid  input  CDB_PORTS  per-port broadcast valid.
REQ-015 cdb_rob_id  input  CDB_PORTS*ROB_BW and cdb_value  input  CDB_PORTS*32: packed tags and values, port 0 in LSBs.
REQ-016 ex_valid  output  1  dispatch to ALU; ex_op 6, ex_pc/ex_imm/ex_v1/ex_v2 32, ex_rob_id ROB_BW: registered operands.

Function
REQ-017 Entry fields: busy, op, pc, imm, rob_id, and per operand a pending bit, tag and 32-bit value.
REQ-018 Issue accepted when issue_valid and !rs_full and !clr_in and rdy_in; written into the lowest-index free entry at the clock edge.
REQ-019 issue_valid while rs_full is ignored; no entry changes.
REQ-020 Wakeup: each cycle, every busy entry with a pending operand whose tag equals a valid cdb_rob_id captures that cdb_value and clears pending.
REQ-021 Issue bypass: an operand issued pending whose tag matches a valid CDB port in the same cycle is stored as ready with that value.
REQ-022 Several ports matching one tag: lowest port index wins.
REQ-023 Ready entry: busy and both operands not pending, evaluated on registered state (a value woken this cycle dispatches no earlier than next cycle).
REQ-024 Select: lowest-index ready entry dispatches; fields are copied to ex_* registers and the entry's busy bit clears at the same edge; latency from readiness to ex_valid = 1 cycle.
REQ-025 At most one dispatch per cycle; ex_valid is low in any cycle following an edge with no dispatch.
REQ-026 A freed entry can be reallocated in the next cycle; same-cycle issue and dispatch to different entries is allowed.
REQ-027 clr_in high (with rdy_in): all busy bits clear, ex_valid is 0 after the edge, and concurrent issue/wakeup are discarded.
REQ-028 rdy_in low: every register holds, including ex_* outputs; clr_in and issue are ignored.

Reset
REQ-029 rst_in high at an edge: all busy and pending bits clear, ex_valid=0, and ex_op/ex_pc/ex_imm/ex_v1/ex_v2/ex_rob_id=0; rs_full=0 after reset.
REQ-030 rst_in overrides clr_in and rdy_in; reset mid-operation discards all entries.

Structure
REQ-031 RSSZ, ROBBW, True/False and opcode/type constants come from the shared defines header; no local duplicates.
REQ-032 One sub-module, rs_pick: a parametrised lowest-index priority encoder (found flag plus index), instantiated twice (free slot, ready slot).

Verification
REQ-033 Reset, then issue ADD with both operands ready, v1=5, v2=7, rob 3 -> next cycle ex_valid=1, ex_v1=5, ex_v2=7, ex_rob_id=3.
REQ-034 Issue with q1 pending on tag 2; two cycles later cdb port1 sends rob 2 value 0x10 -> ex_valid one cycle after broadcast, ex_v1=0x10.
REQ-035 Fill 16 pending entries -> rs_full=1 and a 17th issue is dropped; wake entry 4 -> dispatch frees it, rs_full=0, and the next issue lands in entry 4.
REQ-036 Issue pending on tag 6 while cdb port0 broadcasts rob 6 value 9 in the same cycle -> dispatch next cycle with ex_v1=9.
REQ-037 With 3 entries ready, assert clr_in -> ex_valid=0 afterwards, and no further dispatches.
REQ-038 Hold rdy_in low for 3 cycles while ready entries exist -> ex_* are unchanged and dispatch resumes when rdy_in returns high.
